// File: rtl/pid_sweep_scheduler.sv
// Periodic sequencer for a bank of PID controllers: loads setpoint/PV per motor,
// waits a settle interval, then latches each PID output as that motor's command.
module pid_sweep_scheduler #(
    parameter int unsigned NUM_MOTORS = 6,
    parameter int unsigned PERIOD     = 5000,
    parameter int unsigned SETTLE     = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_write,
    input  logic [7:0]               cfg_addr,
    input  logic [31:0]              cfg_sp,
    input  logic                     cfg_en,
    input  logic [32*NUM_MOTORS-1:0] pv_in,
    input  logic [32*NUM_MOTORS-1:0] pid_output,
    output logic [32*NUM_MOTORS-1:0] pid_sp,
    output logic [32*NUM_MOTORS-1:0] pid_pv,
    output logic [NUM_MOTORS-1:0]    pid_rst_n,
    output logic [32*NUM_MOTORS-1:0] motor_cmd,
    output logic                     busy,
    output logic                     sweep_done,
    output logic                     overrun
);
    localparam int unsigned IW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned CW = $clog2(PERIOD);
    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_MOTORS - 1);
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_LAST    = CW'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_e;

    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   tick;
    logic [IW-1:0]          idx_q;
    logic [SW-1:0]          scnt_q;
    logic [NUM_MOTORS-1:0]  en_q;
    logic [31:0]            sp_shadow_q [NUM_MOTORS];
    logic [31:0]            pid_sp_q    [NUM_MOTORS];
    logic [31:0]            pid_pv_q    [NUM_MOTORS];
    logic [31:0]            motor_cmd_q [NUM_MOTORS];
    logic [31:0]            pv_arr      [NUM_MOTORS];
    logic [31:0]            out_arr     [NUM_MOTORS];
    logic                   busy_q;
    logic                   sweep_done_q;
    logic                   overrun_q;

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    genvar g;
    generate
        for (g = 0; g < NUM_MOTORS; g++) begin : g_pack
            assign pv_arr[g]            = pv_in[32*g +: 32];
            assign out_arr[g]           = pid_output[32*g +: 32];
            assign pid_sp[32*g +: 32]    = pid_sp_q[g];
            assign pid_pv[32*g +: 32]    = pid_pv_q[g];
            assign motor_cmd[32*g +: 32] = motor_cmd_q[g];
        end
    endgenerate

    assign pid_rst_n  = en_q;
    assign busy       = busy_q;
    assign sweep_done = sweep_done_q;
    assign overrun    = overrun_q;

    // Period counter and host-written shadow state; free-running regardless of sweep.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
            en_q  <= '0;
            for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
                sp_shadow_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
                if (cfg_write && (cfg_addr == 8'(i))) begin
                    sp_shadow_q[i] <= cfg_sp;
                    en_q[i]        <= cfg_en;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            scnt_q       <= '0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
                pid_sp_q[i]    <= '0;
                pid_pv_q[i]    <= '0;
                motor_cmd_q[i] <= '0;
            end
        end else begin
            sweep_done_q <= 1'b0;
            // A tick arriving mid-sweep is dropped; the sweep itself runs to completion.
            if (tick && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        state_q <= S_LOAD;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    pid_sp_q[idx_q] <= sp_shadow_q[idx_q];
                    pid_pv_q[idx_q] <= pv_arr[idx_q];
                    scnt_q          <= SETTLE_INIT;
                    state_q         <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (scnt_q == '0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        scnt_q <= scnt_q - SW'(1);
                    end
                end
                S_CAPTURE: begin
                    motor_cmd_q[idx_q] <= en_q[idx_q] ? out_arr[idx_q] : '0;
                    if (idx_q == LAST_IDX) begin
                        state_q      <= S_DONE;
                        sweep_done_q <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                        state_q <= S_LOAD;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
